param_shift_register: RTL and testbench

- Generalised successor of the 4-bit hold/load/shift/clear register that sits on the ALU output path.
- WIDTH-bit register with eight opcodes: the original five, plus rotates and arithmetic shift-right.
- Shifts are by a programmable amount, executed one bit per cycle under a valid/ready handshake with busy/done status.
- Adds carry-out and zero flags for the control unit.

---
 rtl/param_shift_register_pkg.sv | 79 +++++++
 rtl/param_shift_register_step.sv | 33 +++
 rtl/param_shift_register.sv | 173 +++++++++++++++++
 tb/tb_param_shift_register.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Module : param_shift_register_pkg
// Brief  : Opcodes, FSM encoding and the one-bit shift/rotate step function
//          shared by the shift register and its step unit.
// Rev    : 1.0  initial release
// ============================================================================
package param_shift_register_pkg;

  localparam int C_MAX_W = 32;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_ROL   = 3'b110;
  localparam logic [2:0] OP_ASR   = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

  // One step on the low 'width' bits of value; returns {carry, value}.
  // Bits above the active width come back as zero.
  function automatic logic [C_MAX_W:0] shift_step(
    input logic [2:0]         op,
    input logic [C_MAX_W-1:0] value,
    input logic               sin,
    input logic [5:0]         width
  );
    logic [C_MAX_W-1:0] v;
    logic               c;
    logic [4:0]         top;
    logic               fill;
    v    = value;
    c    = 1'b0;
    top  = width[4:0] - 5'd1;
    fill = 1'b0;
    case (op)
      OP_SHR, OP_ROR, OP_ASR: begin
        case (op)
          OP_SHR:  fill = sin;
          OP_ROR:  fill = value[0];
          default: fill = value[top];
        endcase
        c = value[0];
        v = '0;
        for (int i = 0; i < C_MAX_W - 1; i++) begin
          if (i < int'(top)) v[i] = value[i+1];
        end
        v[top] = fill;
      end
      OP_SHL, OP_ROL: begin
        fill = (op == OP_SHL) ? sin : value[top];
        c    = value[top];
        v    = '0;
        v[0] = fill;
        for (int i = 1; i < C_MAX_W; i++) begin
          if (i <= int'(top)) v[i] = value[i-1];
        end
      end
      default: begin
        v = value;
        c = 1'b0;
      end
    endcase
    return {c, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/param_shift_register_step.sv
`default_nettype none
// ============================================================================
// Module : shift_step_unit
// Brief  : Combinational single-bit shift/rotate step for a WIDTH-bit value.
// Rev    : 1.0  initial release
// ============================================================================
module shift_step_unit
  import param_shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_value,
  output logic             carry
);

  logic [C_MAX_W:0] w_res;

  assign w_res      = shift_step(op, C_MAX_W'(value), serial_in, 6'(WIDTH));
  assign next_value = w_res[WIDTH-1:0];
  assign carry      = w_res[C_MAX_W];

  generate
    if (WIDTH < C_MAX_W) begin : g_pad
      logic w_unused_hi;
      assign w_unused_hi = |w_res[C_MAX_W-1:WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/param_shift_register.sv
`default_nettype none
// ============================================================================
// Module : param_shift_register
// Brief  : WIDTH-bit hold/load/shift/rotate/clear register with handshake,
//          carry and zero flags. Define PARAM_SHIFT_REGISTER_BARREL_EN for a
//          single-cycle barrel implementation; default is one bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
module param_shift_register
  import param_shift_register_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         op,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   out,
  output logic               carry_out,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_out, w_out_nxt;
  logic               r_carry, w_carry_nxt;
  logic               r_done, w_done_nxt;
  logic [SHAMT_W-1:0] w_amt;
  logic [WIDTH-1:0]   w_shift_val;
  logic               w_shift_carry;

  generate
    if ((1 << SHAMT_W) == WIDTH) begin : g_no_clamp
      assign w_amt = shamt;
    end else begin : g_clamp
      assign w_amt = (shamt > SHAMT_W'(WIDTH - 1)) ? SHAMT_W'(WIDTH - 1) : shamt;
    end
  endgenerate

`ifdef PARAM_SHIFT_REGISTER_BARREL_EN
  logic [WIDTH-1:0] w_stage [0:WIDTH-1];
  logic             w_cst   [0:WIDTH-1];

  assign w_stage[0] = r_out;
  assign w_cst[0]   = r_carry;

  generate
    for (genvar k = 0; k < WIDTH - 1; k++) begin : g_barrel
      shift_step_unit #(.WIDTH(WIDTH)) u_step (
        .op         (op),
        .value      (w_stage[k]),
        .serial_in  (serial_in),
        .next_value (w_stage[k+1]),
        .carry      (w_cst[k+1])
      );
    end
  endgenerate

  assign w_shift_val   = w_stage[w_amt];
  assign w_shift_carry = w_cst[w_amt];
`else
  logic [SHAMT_W-1:0] r_count, w_count_nxt;
  logic [2:0]         r_op, w_op_nxt;
  logic               r_sin, w_sin_nxt;
  logic [2:0]         w_step_op;
  logic               w_step_sin;

  // Accept edge uses the live inputs; later steps replay the latched copies.
  assign w_step_op  = (r_state == ST_SHIFT) ? r_op  : op;
  assign w_step_sin = (r_state == ST_SHIFT) ? r_sin : serial_in;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .op         (w_step_op),
    .value      (r_out),
    .serial_in  (w_step_sin),
    .next_value (w_shift_val),
    .carry      (w_shift_carry)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_carry_nxt = r_carry;
    w_done_nxt  = 1'b0;
`ifndef PARAM_SHIFT_REGISTER_BARREL_EN
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_sin_nxt   = r_sin;
`endif
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          w_done_nxt = 1'b1;
          case (op)
            OP_LOAD: w_out_nxt = data_in;
            OP_CLEAR: begin
              w_out_nxt   = '0;
              w_carry_nxt = 1'b0;
            end
            default: begin
              if (is_shift_op(op) && (w_amt != '0)) begin
                w_out_nxt   = w_shift_val;
                w_carry_nxt = w_shift_carry;
`ifndef PARAM_SHIFT_REGISTER_BARREL_EN
                if (w_amt != SHAMT_W'(1)) begin
                  w_state_nxt = ST_SHIFT;
                  w_count_nxt = w_amt - SHAMT_W'(1);
                  w_op_nxt    = op;
                  w_sin_nxt   = serial_in;
                  w_done_nxt  = 1'b0;
                end
`endif
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
`ifndef PARAM_SHIFT_REGISTER_BARREL_EN
        w_out_nxt   = w_shift_val;
        w_carry_nxt = w_shift_carry;
        w_count_nxt = r_count - SHAMT_W'(1);
        if (r_count == SHAMT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
`ifndef PARAM_SHIFT_REGISTER_BARREL_EN
      r_count <= '0;
      r_op    <= OP_HOLD;
      r_sin   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_carry <= w_carry_nxt;
      r_done  <= w_done_nxt;
`ifndef PARAM_SHIFT_REGISTER_BARREL_EN
      r_count <= w_count_nxt;
      r_op    <= w_op_nxt;
      r_sin   <= w_sin_nxt;
`endif
    end
  end

  assign out       = r_out;
  assign carry_out = r_carry;
  assign zero      = (r_out == '0);
  assign busy      = (r_state == ST_SHIFT);
  assign op_ready  = (r_state == ST_IDLE);
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_param_shift_register.sv
`default_nettype none
// ============================================================================
// Module : tb_param_shift_register
// Brief  : Directed self-checking bench for param_shift_register (WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_param_shift_register;

  localparam logic [2:0] C_HOLD  = 3'b000;
  localparam logic [2:0] C_LOAD  = 3'b001;
  localparam logic [2:0] C_SHR   = 3'b010;
  localparam logic [2:0] C_SHL   = 3'b011;
  localparam logic [2:0] C_CLEAR = 3'b100;
  localparam logic [2:0] C_ROR   = 3'b101;
  localparam logic [2:0] C_ROL   = 3'b110;
  localparam logic [2:0] C_ASR   = 3'b111;

`ifdef PARAM_SHIFT_REGISTER_BARREL_EN
  localparam bit C_BARREL = 1'b1;
`else
  localparam bit C_BARREL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] op;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] data_in;
  logic [2:0] shamt;
  logic       serial_in;
  logic [7:0] out;
  logic       carry_out;
  logic       zero;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;
  int last_edges;
  int last_busy;

  param_shift_register #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .serial_in (serial_in),
    .out       (out),
    .carry_out (carry_out),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_edges(input int n);
    if (C_BARREL || n <= 1) return 1;
    return n;
  endfunction

  function automatic int exp_busy(input int n);
    if (C_BARREL || n == 0) return 0;
    return n - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] d, input logic [2:0] s, input logic si);
    @(negedge clk);
    op        = o;
    data_in   = d;
    shamt     = s;
    serial_in = si;
    op_valid  = 1'b1;
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] d, input logic [2:0] s, input logic si);
    issue(o, d, s, si);
    last_edges = 1;
    last_busy  = 0;
    while (!done && last_edges < 64) begin
      if (busy) last_busy++;
      @(posedge clk);
      #1;
      last_edges++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int  edges;
    bit  seen_ff;
    rst_n     = 1'b0;
    op        = C_HOLD;
    op_valid  = 1'b0;
    data_in   = '0;
    shamt     = '0;
    serial_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out",   32'(out),       32'h00);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_zero",  32'(zero),      32'd1);
    chk("rst_ready", 32'(op_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a 5-step SHL
    run_op(C_LOAD, 8'hB5, 3'd0, 1'b0);
    chk("mid_load", 32'(out), 32'hB5);
    issue(C_SHL, 8'h00, 3'd5, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_out_pre",  32'(out),  C_BARREL ? 32'hA0 : 32'hD4);
    chk("mid_busy_pre", 32'(busy), C_BARREL ? 32'd0  : 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out",   32'(out),       32'h00);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(C_LOAD, 8'h5A, 3'd0, 1'b0);
    chk("post_rst_load", 32'(out), 32'h5A);

    // SHR by 3 with serial fill 1
    run_op(C_LOAD, 8'h81, 3'd0, 1'b0);
    run_op(C_SHR, 8'h00, 3'd3, 1'b1);
    chk("shr_out",   32'(out),       32'hF0);
    chk("shr_carry", 32'(carry_out), 32'd0);
    chk("shr_edges", 32'(last_edges), 32'(exp_edges(3)));
    chk("shr_busy",  32'(last_busy),  32'(exp_busy(3)));
    @(posedge clk);
    #1;
    chk("shr_done_pulse", 32'(done), 32'd0);

    // ASR then ROL
    run_op(C_LOAD, 8'h96, 3'd0, 1'b0);
    run_op(C_ASR, 8'h00, 3'd2, 1'b0);
    chk("asr_out",   32'(out),       32'hE5);
    chk("asr_carry", 32'(carry_out), 32'd1);
    chk("asr_edges", 32'(last_edges), 32'(exp_edges(2)));
    run_op(C_ROL, 8'h00, 3'd4, 1'b0);
    chk("rol_out",   32'(out),       32'h5E);
    chk("rol_carry", 32'(carry_out), 32'd0);
    chk("rol_busy",  32'(last_busy),  32'(exp_busy(4)));

    // LOAD held valid during a ROR by 7 must wait for op_ready
    run_op(C_LOAD, 8'h01, 3'd0, 1'b0);
    issue(C_ROR, 8'h00, 3'd7, 1'b0);
    chk("ror_ready_after_accept", 32'(op_ready), C_BARREL ? 32'd1 : 32'd0);
    op       = C_LOAD;
    data_in  = 8'hFF;
    op_valid = 1'b1;
    edges    = 1;
    seen_ff  = 1'b0;
    while (!done && edges < 64) begin
      if (out == 8'hFF) seen_ff = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    chk("ror_done",    32'(done),      32'd1);
    chk("ror_out",     32'(out),       32'h02);
    chk("ror_carry",   32'(carry_out), 32'd0);
    chk("ror_edges",   32'(edges),     32'(exp_edges(7)));
    chk("ror_blocked", 32'(seen_ff),   32'd0);
    chk("ror_ready",   32'(op_ready),  32'd1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("held_load_out",   32'(out),       32'hFF);
    chk("held_load_carry", 32'(carry_out), 32'd0);

    // CLEAR clears carry; shamt=0 is a single-cycle no-op
    run_op(C_LOAD, 8'h80, 3'd0, 1'b0);
    run_op(C_ROL, 8'h00, 3'd1, 1'b0);
    chk("rol1_out",   32'(out),       32'h01);
    chk("rol1_carry", 32'(carry_out), 32'd1);
    run_op(C_CLEAR, 8'h00, 3'd0, 1'b0);
    chk("clr_out",   32'(out),       32'h00);
    chk("clr_carry", 32'(carry_out), 32'd0);
    chk("clr_zero",  32'(zero),      32'd1);
    run_op(C_LOAD, 8'h40, 3'd0, 1'b0);
    run_op(C_SHL, 8'h00, 3'd0, 1'b1);
    chk("shl0_out",   32'(out),        32'h40);
    chk("shl0_edges", 32'(last_edges), 32'd1);
    chk("shl0_busy",  32'(last_busy),  32'd0);
    chk("shl0_carry", 32'(carry_out),  32'd0);
    chk("shl0_zero",  32'(zero),       32'd0);

    // Back-to-back: LOAD accepted while SHL's done is high
    run_op(C_LOAD, 8'h80, 3'd0, 1'b0);
    run_op(C_SHL, 8'h00, 3'd1, 1'b0);
    chk("shl1_out",   32'(out),       32'h00);
    chk("shl1_carry", 32'(carry_out), 32'd1);
    chk("shl1_zero",  32'(zero),      32'd1);
    run_op(C_LOAD, 8'h3C, 3'd0, 1'b0);
    chk("b2b_out",   32'(out),        32'h3C);
    chk("b2b_carry", 32'(carry_out),  32'd1);
    chk("b2b_zero",  32'(zero),       32'd0);
    chk("b2b_edges", 32'(last_edges), 32'd1);
    run_op(C_HOLD, 8'hAA, 3'd3, 1'b1);
    chk("hold_out",   32'(out),        32'h3C);
    chk("hold_edges", 32'(last_edges), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
